// File: rtl/fc_in_collector_if.sv
// Stream-in / parallel-out bundle between the activation source, the collector and the FC layer.
interface fc_in_collector_if #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x [0:IN-1];
  logic             frame_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, x, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, x, frame_err
  );
endinterface

// File: rtl/fc_in_collector.sv
// Packs IN serial activations into a bank and holds it as the FC layer's parallel input until taken.
// One cycle from the final beat to out_valid; in_ready is low for the whole time a frame is held.
module fc_in_collector #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fc_in_collector_if.slave   bus
);

  localparam int            CW   = $clog2(IN);
  localparam logic [CW-1:0] LAST = CW'(IN - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic             frame_err_q;
  logic [WIDTH-1:0] x_q [IN];
  logic             accept;

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.x         = x_q;

  assign accept = bus.in_valid && (state_q == FILL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < IN; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            x_q[cnt_q] <= bus.in_data;
            if (cnt_q == LAST) begin
              // Bank is full regardless of in_last; a missing last is flagged but the frame still goes out.
              cnt_q       <= '0;
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              frame_err_q <= !bus.in_last;
            end else if (bus.in_last) begin
              // Early end: restart the frame; stale bank entries are overwritten before any presentation.
              cnt_q       <= '0;
              frame_err_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q     <= FILL;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= FILL;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_in_collector.sv
// Directed bench for fc_in_collector: a queue-based frame model checked against the DUT every cycle.
module tb_fc_in_collector;
  localparam int WIDTH = 8;
  localparam int IN    = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fc_in_collector_if #(.WIDTH(WIDTH), .IN(IN)) bus ();

  fc_in_collector #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: what the frame must look like from the accepted-beat history alone.
  logic [WIDTH-1:0] frame [$];
  logic [WIDTH-1:0] exp_x [IN];
  bit               m_hold  = 0;
  bit               exp_err = 0;
  bit               chk_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_err = 0;
    if (rst) begin
      m_hold = 0;
      frame.delete();
      for (int i = 0; i < IN; i++) exp_x[i] = '0;
      chk_en = 1;
    end else if (m_hold) begin
      if (bus.out_ready) m_hold = 0;
    end else if (bus.in_valid) begin
      exp_x[frame.size()] = bus.in_data;
      frame.push_back(bus.in_data);
      if (frame.size() == IN) begin
        m_hold  = 1;
        exp_err = !bus.in_last;
        frame.delete();
      end else if (bus.in_last) begin
        exp_err = 1;
        frame.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int bad;
      bad = -1;
      chk("in_ready", 32'(bus.in_ready), 32'(!m_hold));
      chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
      chk("frame_err", 32'(bus.frame_err), 32'(exp_err));
      for (int i = 0; i < IN; i++) begin
        if (bad < 0 && bus.x[i] !== exp_x[i]) bad = i;
      end
      if (bad < 0) chk("x_bank", 32'(bus.x[0]), 32'(exp_x[0]));
      else         chk($sformatf("x[%0d]", bad), 32'(bus.x[bad]), 32'(exp_x[bad]));
    end
  end

  // Driver runs on negedges; each send returns one negedge after the posedge that accepted the beat.
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int n;
    n = 0;
    while (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      n++;
      if (n > 500) begin
        chk("send_timeout", 32'(bus.in_ready), 32'd1);
        return;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = WIDTH'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic take();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("take_out_valid", 32'(bus.out_valid), 32'd0);
    chk("take_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_reset(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset(2);

    // 1: reset mid-stream clears the bank
    for (int i = 0; i < 30; i++) send(WIDTH'(i + 7), 1'b0);
    do_reset(2);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_x10", 32'(bus.x[10]), 32'd0);

    // 2: continuous frame, held, then taken
    for (int i = 0; i < IN; i++) send(WIDTH'(i), i == IN - 1);
    bus.in_valid = 1'b0;
    chk("cont_out_valid", 32'(bus.out_valid), 32'd1);
    chk("cont_x0", 32'(bus.x[0]), 32'h00);
    chk("cont_x127", 32'(bus.x[127]), 32'h7F);
    idle(10);
    chk("hold_x64", 32'(bus.x[64]), 32'h40);
    chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    take();

    // 3: ~40% valid duty, values -1, -2, ...
    for (int i = 0; i < IN; i++) begin
      while ($urandom_range(0, 99) >= 40) idle(1);
      send(WIDTH'(-(i + 1)), i == IN - 1);
    end
    bus.in_valid = 1'b0;
    chk("bub_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bub_x1", 32'(bus.x[1]), 32'hFE);
    chk("bub_x127", 32'(bus.x[127]), 32'h80);
    idle(3);
    take();

    // 4: early last then a clean frame of 5A
    for (int i = 0; i <= 50; i++) send(WIDTH'(i + 1), i == 50);
    bus.in_valid = 1'b0;
    chk("early_err", 32'(bus.frame_err), 32'd1);
    chk("early_out_valid", 32'(bus.out_valid), 32'd0);
    idle(2);
    for (int i = 0; i < IN; i++) send(8'h5A, i == IN - 1);
    bus.in_valid = 1'b0;
    chk("5a_x5", 32'(bus.x[5]), 32'h5A);
    chk("5a_x100", 32'(bus.x[100]), 32'h5A);
    take();

    // 5: missing last -> error and out_valid together
    for (int i = 0; i < IN; i++) send(WIDTH'(i * 3), 1'b0);
    bus.in_valid = 1'b0;
    chk("miss_err", 32'(bus.frame_err), 32'd1);
    chk("miss_out_valid", 32'(bus.out_valid), 32'd1);
    chk("miss_x100", 32'(bus.x[100]), 32'h2C);
    idle(1);
    take();

    // 6: reset at beat 70, then 128 beats of 80
    for (int i = 0; i < 70; i++) send(WIDTH'(i), 1'b0);
    do_reset(1);
    for (int i = 0; i < IN; i++) send(8'h80, i == IN - 1);
    bus.in_valid = 1'b0;
    chk("r6_out_valid", 32'(bus.out_valid), 32'd1);
    chk("r6_x64", 32'(bus.x[64]), 32'h80);
    idle(2);
    take();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
